cmn_real_demux_onehot: RTL and testbench

CMN_REAL_DEMUX_ONEHOT -- requirements
Module: cmn_real_demux_onehot

---
 rtl/cmn_real_demux_onehot_pkg.sv | 28 ++
 rtl/cmn_pld_slot.sv | 57 +++++
 rtl/cmn_real_demux_onehot.sv | 101 ++++++++++
 tb/tb_cmn_real_demux_onehot.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cmn_real_demux_onehot_pkg.sv
// ----------------------------------------------------------------------------
// cmn_real_demux_onehot_pkg
// Shared constants and helpers for the onehot demultiplexer.
//   DROP_CNT_W    : width of the saturating dropped-transfer counter
//   ONEHOT_MAX_W  : widest select vector accepted by is_onehot()
//   is_onehot()   : true when exactly one bit of the (zero-extended) vector is set
// ----------------------------------------------------------------------------
package cmn_real_demux_onehot_pkg;

    localparam int unsigned DROP_CNT_W   = 16;
    localparam int unsigned ONEHOT_MAX_W = 64;

    // Single pass: 'multi' latches once a second set bit is seen after the first.
    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] vec);
        logic seen;
        logic multi;
        seen  = 1'b0;
        multi = 1'b0;
        for (int unsigned i = 0; i < ONEHOT_MAX_W; i++) begin
            if (vec[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
            end
        end
        return seen & ~multi;
    endfunction

endpackage

// File: rtl/cmn_pld_slot.sv
// ----------------------------------------------------------------------------
// cmn_pld_slot
// One-entry valid/ready payload register. Supports load, drain and a
// simultaneous load+drain so a lane sustains one transfer per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : write pld_i this cycle (caller guarantees free_o is high)
//   pld_i      : payload to store
//   rdy_i      : downstream ready
//   vld_o      : slot holds a payload
//   pld_o      : stored payload (stable while vld_o & ~rdy_i)
//   free_o     : slot can take a load this cycle (empty or draining)
// ----------------------------------------------------------------------------
module cmn_pld_slot #(
    parameter type PLD_TYPE = logic [31:0]
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load_i,
    input  PLD_TYPE pld_i,
    input  logic    rdy_i,
    output logic    vld_o,
    output PLD_TYPE pld_o,
    output logic    free_o
);

    logic    full_q;
    logic    full_d;
    PLD_TYPE pld_q;
    PLD_TYPE pld_d;

    // Load has priority over drain: a same-cycle load+drain keeps the slot full.
    always_comb begin
        full_d = full_q;
        pld_d  = pld_q;
        if (load_i) begin
            full_d = 1'b1;
            pld_d  = pld_i;
        end else if (full_q && rdy_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            pld_q  <= '0;
        end else begin
            full_q <= full_d;
            pld_q  <= pld_d;
        end
    end

    assign vld_o  = full_q;
    assign pld_o  = pld_q;
    assign free_o = ~full_q | rdy_i;

endmodule

// File: rtl/cmn_real_demux_onehot.sv
// ----------------------------------------------------------------------------
// cmn_real_demux_onehot
// Routes one input payload per cycle to the lane named by a onehot select.
// Each lane is an independent one-entry register; a stalled lane only blocks
// inputs aimed at it. Malformed selects (zero-hot or multi-hot) are consumed,
// dropped, flagged on err_select one cycle later and counted in drop_cnt.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_vld / in_rdy   : input handshake
//   in_select_onehot  : destination lane, qualified by in_vld
//   in_pld            : input payload
//   v_out_vld/_rdy    : per-lane output handshake
//   v_out_pld         : per-lane output payload
//   err_select        : one-cycle pulse after each dropped transfer
//   drop_cnt          : saturating count of dropped transfers
// ----------------------------------------------------------------------------
module cmn_real_demux_onehot
    import cmn_real_demux_onehot_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned PLD_WIDTH = 32,
    parameter type         PLD_TYPE  = logic [PLD_WIDTH-1:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_vld,
    output logic                   in_rdy,
    input  logic [WIDTH-1:0]       in_select_onehot,
    input  PLD_TYPE                in_pld,
    output logic [WIDTH-1:0]       v_out_vld,
    input  logic [WIDTH-1:0]       v_out_rdy,
    output PLD_TYPE [WIDTH-1:0]    v_out_pld,
    output logic                   err_select,
    output logic [DROP_CNT_W-1:0]  drop_cnt
);

    logic                  sel_legal;
    logic [WIDTH-1:0]      lane_free;
    logic [WIDTH-1:0]      lane_load;
    logic                  lane_rdy;
    logic                  accept_legal;
    logic                  drop_now;

    logic                  err_q;
    logic                  err_d;
    logic [DROP_CNT_W-1:0] cnt_q;
    logic [DROP_CNT_W-1:0] cnt_d;

    assign sel_legal = is_onehot(ONEHOT_MAX_W'(in_select_onehot));

    // Onehot-mux style AND-OR: select bit gates each lane's free flag, then OR.
    always_comb begin
        lane_rdy = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            lane_rdy = lane_rdy | (in_select_onehot[i] & lane_free[i]);
        end
    end

    // in_rdy for a legal select is independent of in_vld; an illegal select is
    // always consumed so a bad transfer can never wedge the input.
    assign in_rdy       = sel_legal ? lane_rdy : 1'b1;
    assign accept_legal = in_vld & sel_legal & lane_rdy;
    assign lane_load    = accept_legal ? in_select_onehot : '0;
    assign drop_now     = in_vld & ~sel_legal;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        cmn_pld_slot #(
            .PLD_TYPE (PLD_TYPE)
        ) u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (lane_load[g]),
            .pld_i  (in_pld),
            .rdy_i  (v_out_rdy[g]),
            .vld_o  (v_out_vld[g]),
            .pld_o  (v_out_pld[g]),
            .free_o (lane_free[g])
        );
    end

    always_comb begin
        err_d = drop_now;
        cnt_d = cnt_q;
        if (drop_now && (cnt_q != '1)) begin
            cnt_d = cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err_select = err_q;
    assign drop_cnt   = cnt_q;

endmodule

// File: tb/tb_cmn_real_demux_onehot.sv
`timescale 1ns/1ps
module tb_cmn_real_demux_onehot;

    logic             clk;
    logic             rst_n;
    logic             in_vld;
    logic             in_rdy;
    logic [3:0]       in_select_onehot;
    logic [31:0]      in_pld;
    logic [3:0]       v_out_vld;
    logic [3:0]       v_out_rdy;
    logic [3:0][31:0] v_out_pld;
    logic             err_select;
    logic [15:0]      drop_cnt;

    int n_checks;
    int n_errors;

    logic [31:0] lane_q [4][$];
    logic [15:0] err_q [$];
    logic [15:0] exp_drop;

    cmn_real_demux_onehot #(
        .WIDTH     (4),
        .PLD_WIDTH (32)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_vld           (in_vld),
        .in_rdy           (in_rdy),
        .in_select_onehot (in_select_onehot),
        .in_pld           (in_pld),
        .v_out_vld        (v_out_vld),
        .v_out_rdy        (v_out_rdy),
        .v_out_pld        (v_out_pld),
        .err_select       (err_select),
        .drop_cnt         (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge. Drives one cycle of stimulus, checks
    // in_rdy against the hand-computed value and records expected outputs.
    task automatic step(input logic vld, input logic [3:0] sel, input logic [31:0] pld,
                        input logic [3:0] ordy, input logic exp_rdy, input string name);
        in_vld           = vld;
        in_select_onehot = sel;
        in_pld           = pld;
        v_out_rdy        = ordy;
        @(negedge clk);
        if (vld) begin
            chk(name, in_rdy, exp_rdy);
            if (exp_rdy) begin
                if ($countones(sel) == 1) begin
                    for (int i = 0; i < 4; i++) if (sel[i]) lane_q[i].push_back(pld);
                end else begin
                    exp_drop = (exp_drop == 16'hFFFF) ? 16'hFFFF : exp_drop + 16'd1;
                    err_q.push_back(exp_drop);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a lane transfers or err_select pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (v_out_vld[i] && v_out_rdy[i]) begin
                    n_checks++;
                    if (lane_q[i].size() == 0) begin
                        n_errors++;
                        $display("FAIL lane%0d_unexpected: got %h expected none", i, v_out_pld[i]);
                    end else begin
                        logic [31:0] e;
                        e = lane_q[i].pop_front();
                        if (v_out_pld[i] !== e) begin
                            n_errors++;
                            $display("FAIL lane%0d_pld: got %h expected %h", i, v_out_pld[i], e);
                        end
                    end
                end
            end
            if (err_select) begin
                n_checks++;
                if (err_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL err_unexpected: got pulse expected none (drop_cnt %h)", drop_cnt);
                end else begin
                    logic [15:0] ed;
                    ed = err_q.pop_front();
                    if (drop_cnt !== ed) begin
                        n_errors++;
                        $display("FAIL err_drop_cnt: got %h expected %h", drop_cnt, ed);
                    end
                end
            end
        end
    end

    initial begin
        n_checks         = 0;
        n_errors         = 0;
        exp_drop         = 16'd0;
        rst_n            = 1'b0;
        in_vld           = 1'b0;
        in_select_onehot = 4'b0000;
        in_pld           = 32'h0;
        v_out_rdy        = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", {28'h0, v_out_vld}, 32'h0);
        chk("rst_err", {31'h0, err_select}, 32'h0);
        chk("rst_drop", {16'h0, drop_cnt}, 32'h0);
        for (int i = 0; i < 4; i++) chk("rst_pld", v_out_pld[i], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single transfer, first cycle after reset
        step(1'b1, 4'b0100, 32'hA5A5_0001, 4'b0000, 1'b1, "single_rdy");
        in_vld = 1'b0;
        chk("single_vld", {28'h0, v_out_vld}, 32'h4);
        chk("single_pld", v_out_pld[2], 32'hA5A5_0001);
        step(1'b0, 4'b0000, 32'h0, 4'b0100, 1'b0, "single_drain");
        chk("single_empty", {28'h0, v_out_vld}, 32'h0);

        // Backpressure on lane 1, then same-cycle drain and load
        step(1'b1, 4'b0010, 32'hB000_0001, 4'b0000, 1'b1, "bp_load1");
        step(1'b1, 4'b0010, 32'hB000_0002, 4'b0000, 1'b0, "bp_blocked");
        chk("bp_held_vld", {28'h0, v_out_vld}, 32'h2);
        chk("bp_held_pld", v_out_pld[1], 32'hB000_0001);
        step(1'b1, 4'b0010, 32'hB000_0002, 4'b0010, 1'b1, "bp_drain_load");
        chk("bp_swap_vld", {28'h0, v_out_vld}, 32'h2);
        chk("bp_swap_pld", v_out_pld[1], 32'hB000_0002);
        step(1'b0, 4'b0000, 32'h0, 4'b0010, 1'b0, "bp_drain");
        chk("bp_empty", {28'h0, v_out_vld}, 32'h0);

        // Independence: lane 0 stalled, lane 3 flows
        step(1'b1, 4'b0001, 32'hC000_0000, 4'b0000, 1'b1, "ind_load0");
        step(1'b1, 4'b1000, 32'hC000_0003, 4'b1000, 1'b1, "ind_load3");
        chk("ind_vld", {28'h0, v_out_vld}, 32'h9);
        chk("ind_pld3", v_out_pld[3], 32'hC000_0003);
        step(1'b1, 4'b0001, 32'hC000_00FF, 4'b1000, 1'b0, "ind_lane0_blocked");
        chk("ind_vld_after", {28'h0, v_out_vld}, 32'h1);
        chk("ind_pld0", v_out_pld[0], 32'hC000_0000);

        // Illegal selects: zero-hot then multi-hot
        step(1'b1, 4'b0000, 32'hD000_0000, 4'b0000, 1'b1, "ill_zero");
        step(1'b1, 4'b0110, 32'hD000_0001, 4'b0000, 1'b1, "ill_multi");
        chk("ill_err_hi", {31'h0, err_select}, 32'h1);
        step(1'b0, 4'b0110, 32'hD000_0002, 4'b0000, 1'b0, "ill_idle");
        chk("ill_err_lo", {31'h0, err_select}, 32'h0);
        chk("ill_drop", {16'h0, drop_cnt}, 32'h2);
        chk("ill_vld", {28'h0, v_out_vld}, 32'h1);
        chk("ill_pld0", v_out_pld[0], 32'hC000_0000);

        // Saturation
        for (int n = 0; n < 65535; n++) begin
            step(1'b1, (n % 2 == 0) ? 4'b0000 : 4'b1111, 32'hE000_0000, 4'b0000, 1'b1, "sat_fill");
        end
        chk("sat_full", {16'h0, drop_cnt}, 32'hFFFF);
        step(1'b1, 4'b0011, 32'hE000_0001, 4'b0000, 1'b1, "sat_extra");
        chk("sat_err", {31'h0, err_select}, 32'h1);
        chk("sat_hold", {16'h0, drop_cnt}, 32'hFFFF);
        step(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0, "sat_idle");

        // Mid-stream asynchronous reset with all lanes full
        step(1'b1, 4'b0010, 32'hF000_0001, 4'b0000, 1'b1, "rst_fill1");
        step(1'b1, 4'b0100, 32'hF000_0002, 4'b0000, 1'b1, "rst_fill2");
        step(1'b1, 4'b1000, 32'hF000_0003, 4'b0000, 1'b1, "rst_fill3");
        in_vld = 1'b0;
        chk("rst_all_full", {28'h0, v_out_vld}, 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", {28'h0, v_out_vld}, 32'h0);
        chk("arst_drop", {16'h0, drop_cnt}, 32'h0);
        chk("arst_err", {31'h0, err_select}, 32'h0);
        for (int i = 0; i < 4; i++) lane_q[i].delete();
        exp_drop = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 4'b0001, 32'h1234_5678, 4'b0000, 1'b1, "post_rst_rdy");
        in_vld = 1'b0;
        chk("post_rst_vld", {28'h0, v_out_vld}, 32'h1);
        chk("post_rst_pld", v_out_pld[0], 32'h1234_5678);
        step(1'b0, 4'b0000, 32'h0, 4'b0001, 1'b0, "post_rst_drain");
        chk("post_rst_empty", {28'h0, v_out_vld}, 32'h0);

        for (int i = 0; i < 4; i++) chk("lane_q_empty", lane_q[i].size(), 32'h0);
        chk("err_q_empty", err_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
